// File: rtl/tx_frame_scheduler.sv
// Two-queue transmit frame scheduler in front of the 1G MAC byte path.
// Grants whole frames with strict priority: time-sensitive (TS) first, then
// best-effort (BE) when the BE gate is open. Each granted frame is read one
// byte per cycle and sent to the MAC as one contiguous burst. Short frames are
// zero-padded to MIN_LEN. At least IFG_CYCLES idle cycles follow each burst.
module tx_frame_scheduler #(
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int IFG_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ts_req,
    input  logic [10:0] iv_ts_len,
    output logic        o_ts_ack,
    output logic        o_ts_rd,
    input  logic [7:0]  iv_ts_data,
    input  logic        i_be_req,
    input  logic [10:0] iv_be_len,
    output logic        o_be_ack,
    output logic        o_be_rd,
    input  logic [7:0]  iv_be_data,
    input  logic        i_be_gate,
    output logic        o_data_wr,
    output logic [7:0]  ov_data,
    output logic        o_busy,
    output logic [15:0] ov_ts_tx_cnt,
    output logic [15:0] ov_be_tx_cnt,
    output logic [15:0] ov_drop_cnt
);

    typedef enum logic [1:0] {IDLE, READ, PAD, GAP} state_t;

    localparam logic [10:0] MIN_LEN_W  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W  = 11'(MAX_LEN);
    localparam logic [7:0]  GAP_LOAD   = 8'(IFG_CYCLES - 1);

    state_t      state, state_nxt;
    logic [10:0] len_q, len_nxt;     // byte count of the frame being sent
    logic [10:0] idx, idx_nxt;       // bytes issued so far, data and padding
    logic [7:0]  gap_cnt, gap_nxt;   // remaining GAP cycles before re-arbitration
    logic        sel_ts, sel_ts_nxt; // 1: frame comes from the TS queue
    logic        ack_ts_q, ack_be_q;

    logic        arb_ok, grant_ts, grant_be, grant, len_bad;
    logic [10:0] grant_len;
    logic        issue, issue_pad, issue_last, drop_inc;

    // Byte pipeline: stage 1 marks the cycle the queue presents the byte,
    // stage 2 is the registered MAC write.
    logic        v1, pad1, last1, ts1;

    // Arbitration. It runs in IDLE, and in the final GAP cycle so that the
    // grant latency overlaps the inter-frame gap. The cycle in which an ack
    // is visible is skipped because the requester still shows the old frame.
    always_comb begin
        arb_ok    = ((state == IDLE) && !ack_ts_q && !ack_be_q) ||
                    ((state == GAP) && (gap_cnt == 8'd0));
        grant_ts  = arb_ok && i_ts_req;
        grant_be  = arb_ok && !i_ts_req && i_be_req && i_be_gate;
        grant     = grant_ts || grant_be;
        grant_len = grant_ts ? iv_ts_len : iv_be_len;
        len_bad   = (grant_len == 11'd0) || (grant_len > MAX_LEN_W);
    end

    // Next-state logic and per-cycle byte issue control.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt  = state;
        len_nxt    = len_q;
        idx_nxt    = idx;
        gap_nxt    = gap_cnt;
        sel_ts_nxt = sel_ts;
        issue      = 1'b0;
        issue_pad  = 1'b0;
        issue_last = 1'b0;
        drop_inc   = 1'b0;

        case (state)
            IDLE, GAP: begin
                if (state == GAP) begin
                    if (gap_cnt != 8'd0) gap_nxt = gap_cnt - 8'd1;
                    else                 state_nxt = IDLE;
                end
                if (grant) begin
                    sel_ts_nxt = grant_ts;
                    if (len_bad) begin
                        // Rejected frame: acked and counted, no gap imposed.
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = READ;
                        len_nxt   = grant_len;
                        idx_nxt   = 11'd0;
                    end
                end
            end
            READ: begin
                issue   = 1'b1;
                idx_nxt = idx + 11'd1;
                if (idx == len_q - 11'd1) begin
                    if (len_q < MIN_LEN_W) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt  = GAP;
                        gap_nxt    = GAP_LOAD;
                        issue_last = 1'b1;
                    end
                end
            end
            PAD: begin
                issue     = 1'b1;
                issue_pad = 1'b1;
                idx_nxt   = idx + 11'd1;
                if (idx == MIN_LEN_W - 11'd1) begin
                    state_nxt  = GAP;
                    gap_nxt    = GAP_LOAD;
                    issue_last = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, frame context and one-cycle ack pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            len_q    <= 11'd0;
            idx      <= 11'd0;
            gap_cnt  <= 8'd0;
            sel_ts   <= 1'b0;
            ack_ts_q <= 1'b0;
            ack_be_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state    <= state_nxt;
            len_q    <= len_nxt;
            idx      <= idx_nxt;
            gap_cnt  <= gap_nxt;
            sel_ts   <= sel_ts_nxt;
            ack_ts_q <= grant_ts;
            ack_be_q <= grant_be;
        end
    end

    // Byte pipeline toward the MAC; padding bytes and idle cycles drive zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1        <= 1'b0;
            pad1      <= 1'b0;
            last1     <= 1'b0;
            ts1       <= 1'b0;
            o_data_wr <= 1'b0;
            ov_data   <= 8'h00;
        end else begin
            v1        <= issue;
            pad1      <= issue_pad;
            last1     <= issue_last;
            ts1       <= sel_ts;
            o_data_wr <= v1;
            ov_data   <= (v1 && !pad1) ? (ts1 ? iv_ts_data : iv_be_data) : 8'h00;
        end
    end

    // Statistics: a frame counts when its last byte is written to the MAC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_ts_tx_cnt <= 16'd0;
            ov_be_tx_cnt <= 16'd0;
            ov_drop_cnt  <= 16'd0;
        end else begin
            if (v1 && last1 && ts1)  ov_ts_tx_cnt <= ov_ts_tx_cnt + 16'd1;
            if (v1 && last1 && !ts1) ov_be_tx_cnt <= ov_be_tx_cnt + 16'd1;
            if (drop_inc)            ov_drop_cnt  <= ov_drop_cnt + 16'd1;
        end
    end

    assign o_ts_ack = ack_ts_q;
    assign o_be_ack = ack_be_q;
    assign o_ts_rd  = (state == READ) && sel_ts;
    assign o_be_rd  = (state == READ) && !sel_ts;
    assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler. A frame-level reference model
// decides grants from the queue contents and timing rules, and schedules the
// expected ack/rd/write activity per cycle. A monitor compares every cycle.
module tb_tx_frame_scheduler;

    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;
    localparam int IFG     = 16;
    localparam int NC      = 32768;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ts_req = 1'b0, i_be_req = 1'b0, i_be_gate = 1'b0;
    logic [10:0] iv_ts_len = '0, iv_be_len = '0;
    logic [7:0]  iv_ts_data = '0, iv_be_data = '0;
    logic        o_ts_ack, o_ts_rd, o_be_ack, o_be_rd, o_data_wr, o_busy;
    logic [7:0]  ov_data;
    logic [15:0] ov_ts_tx_cnt, ov_be_tx_cnt, ov_drop_cnt;

    tx_frame_scheduler #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ts_req(i_ts_req), .iv_ts_len(iv_ts_len), .o_ts_ack(o_ts_ack),
        .o_ts_rd(o_ts_rd), .iv_ts_data(iv_ts_data),
        .i_be_req(i_be_req), .iv_be_len(iv_be_len), .o_be_ack(o_be_ack),
        .o_be_rd(o_be_rd), .iv_be_data(iv_be_data), .i_be_gate(i_be_gate),
        .o_data_wr(o_data_wr), .ov_data(ov_data), .o_busy(o_busy),
        .ov_ts_tx_cnt(ov_ts_tx_cnt), .ov_be_tx_cnt(ov_be_tx_cnt),
        .ov_drop_cnt(ov_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int id; int len; } frame_t;
    typedef struct { int cyc; logic [7:0] data; bit last; bit is_ts; } wr_t;

    frame_t ts_q[$], be_q[$];
    wr_t    sb[$];
    bit     exp_ts_ack[NC], exp_be_ack[NC], exp_ts_rd[NC], exp_be_rd[NC], exp_drop[NC];

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [15:0] exp_ts_cnt = '0, exp_be_cnt = '0, exp_drop_cnt = '0;

    // Reference-model state
    int free_at = 0, pop_ts_at = -1, pop_be_at = -1, next_id = 1;
    int last_grant_t = -1000;
    bit gate = 1'b0;
    bit act_valid = 1'b0, act_ts = 1'b0;
    int act_id = 0, act_t = 0, act_len = 0;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] fbyte(input int id, input int k);
        return 8'((id * 73 + k * 29) ^ (k >> 4) ^ (id << 3));
    endfunction

    function automatic int padded(input int len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

    task automatic add_ts(input int len);
        frame_t f;
        f.id = next_id++; f.len = len;
        ts_q.push_back(f);
    endtask

    task automatic add_be(input int len);
        frame_t f;
        f.id = next_id++; f.len = len;
        be_q.push_back(f);
    endtask

    // Frame-level grant: schedule everything the DUT must show for this frame.
    task automatic grant(input bit is_ts, input frame_t f);
        int t;
        int pl;
        wr_t e;
        t = cyc;
        if (is_ts) begin exp_ts_ack[t+1] = 1'b1; pop_ts_at = t + 2; end
        else       begin exp_be_ack[t+1] = 1'b1; pop_be_at = t + 2; end
        if (f.len == 0 || f.len > MAX_LEN) begin
            exp_drop[t+1] = 1'b1;
            free_at = t + 2;
        end else begin
            pl = padded(f.len);
            for (int k = 0; k < f.len; k++) begin
                if (is_ts) exp_ts_rd[t+1+k] = 1'b1;
                else       exp_be_rd[t+1+k] = 1'b1;
            end
            for (int k = 0; k < pl; k++) begin
                e.cyc   = t + 3 + k;
                e.data  = (k < f.len) ? fbyte(f.id, k) : 8'h00;
                e.last  = (k == pl - 1);
                e.is_ts = is_ts;
                sb.push_back(e);
            end
            act_valid = 1'b1; act_ts = is_ts; act_id = f.id; act_t = t; act_len = f.len;
            free_at = t + pl + IFG;
            last_grant_t = t;
        end
    endtask

    // One model cycle, run at the falling edge: drive inputs, maybe grant.
    task automatic model_step();
        if (pop_ts_at == cyc) begin ts_q.delete(0); pop_ts_at = -1; end
        if (pop_be_at == cyc) begin be_q.delete(0); pop_be_at = -1; end
        i_ts_req  = (ts_q.size() > 0);
        iv_ts_len = (ts_q.size() > 0) ? 11'(ts_q[0].len) : 11'($urandom);
        i_be_req  = (be_q.size() > 0);
        iv_be_len = (be_q.size() > 0) ? 11'(be_q[0].len) : 11'($urandom);
        i_be_gate = gate;
        iv_ts_data = 8'($urandom);
        iv_be_data = 8'($urandom);
        if (act_valid && cyc >= act_t + 2 && cyc <= act_t + act_len + 1) begin
            if (act_ts) iv_ts_data = fbyte(act_id, cyc - act_t - 2);
            else        iv_be_data = fbyte(act_id, cyc - act_t - 2);
        end
        if (cyc >= free_at && pop_ts_at < 0 && pop_be_at < 0) begin
            if (ts_q.size() > 0)            grant(1'b1, ts_q[0]);
            else if (be_q.size() > 0 && gate) grant(1'b0, be_q[0]);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge i_clk);
            model_step();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((ts_q.size() > 0 || be_q.size() > 0 || sb.size() > 0 || cyc <= free_at)
               && n < budget) begin
            @(negedge i_clk);
            model_step();
            n++;
        end
        check("drain_timeout", sb.size() + ts_q.size() + be_q.size(), 0);
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom % 20);
        case (r)
            0:       return 0;
            1:       return 1515 + int'($urandom % 533);
            2:       return MAX_LEN;
            3:       return 1;
            4:       return MIN_LEN - 1;
            5:       return MIN_LEN;
            6:       return 200 + int'($urandom % 600);
            default: return 1 + int'($urandom % 120);
        endcase
    endfunction

    // Monitor: per-cycle comparison against the scheduled expectations.
    task automatic monitor_cycle();
        int c;
        wr_t e;
        c = cyc;
        if (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            check("data_wr", o_data_wr, 1);
            check("data", ov_data, e.data);
            check("busy_in_frame", o_busy, 1);
            if (e.last) begin
                if (e.is_ts) exp_ts_cnt++;
                else         exp_be_cnt++;
            end
        end else begin
            check("data_wr_idle", o_data_wr, 0);
            check("data_idle_zero", ov_data, 0);
        end
        if (exp_drop[c]) exp_drop_cnt++;
        check("ts_ack", o_ts_ack, exp_ts_ack[c]);
        check("be_ack", o_be_ack, exp_be_ack[c]);
        check("ts_rd", o_ts_rd, exp_ts_rd[c]);
        check("be_rd", o_be_rd, exp_be_rd[c]);
        check("ts_cnt", ov_ts_tx_cnt, exp_ts_cnt);
        check("be_cnt", ov_be_tx_cnt, exp_be_cnt);
        check("drop_cnt", ov_drop_cnt, exp_drop_cnt);
    endtask

    initial forever begin
        @(negedge i_clk);
        #1;
        if (mon_en) monitor_cycle();
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_wr"}, o_data_wr, 0);
        check({tag, "_data"}, ov_data, 0);
        check({tag, "_ts_rd"}, o_ts_rd, 0);
        check({tag, "_be_rd"}, o_be_rd, 0);
        check({tag, "_acks"}, {o_ts_ack, o_be_ack}, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_ts_cnt"}, ov_ts_tx_cnt, 0);
        check({tag, "_be_cnt"}, ov_be_tx_cnt, 0);
        check({tag, "_drop_cnt"}, ov_drop_cnt, 0);
    endtask

    initial begin
        // Power-on reset
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        check_reset_outputs("por");
        @(negedge i_clk);
        i_rst   = 1'b0;
        free_at = cyc;
        mon_en  = 1'b1;

        // Single TS frame, long enough to need no padding
        add_ts(100);
        wait_idle(2000);
        check("t1_ts_cnt", ov_ts_tx_cnt, 1);

        // Short BE frame: 20 data bytes then 40 zero pad bytes
        gate = 1'b1;
        add_be(20);
        wait_idle(2000);
        check("t2_be_cnt", ov_be_tx_cnt, 1);

        // Simultaneous requests: TS first, BE after exactly one gap
        add_ts(64);
        add_be(64);
        wait_idle(2000);
        check("t3_ts_cnt", ov_ts_tx_cnt, 2);
        check("t3_be_cnt", ov_be_tx_cnt, 2);

        // Gate closed holds BE off; closing mid-frame does not truncate
        gate = 1'b0;
        add_be(80);
        step_n(50);
        gate = 1'b1;
        step_n(10);
        gate = 1'b0;
        step_n(20);
        gate = 1'b1;
        wait_idle(2000);
        check("t4_be_cnt", ov_be_tx_cnt, 3);

        // Illegal lengths are acked and dropped; next legal frame has no gap
        add_ts(0);
        add_ts(1515);
        add_ts(70);
        wait_idle(2000);
        check("t5_drop_cnt", ov_drop_cnt, 2);
        check("t5_ts_cnt", ov_ts_tx_cnt, 3);

        // Boundary lengths
        add_be(MIN_LEN - 1);
        add_be(MIN_LEN);
        add_ts(1);
        add_ts(MAX_LEN);
        wait_idle(4000);

        // Randomized traffic with gate toggling
        for (int i = 0; i < 6000; i++) begin
            @(negedge i_clk);
            if ($urandom % 40 == 0 && ts_q.size() < 3) add_ts(rand_len());
            if ($urandom % 25 == 0 && be_q.size() < 3) add_be(rand_len());
            if ($urandom % 30 == 0) gate = ~gate;
            model_step();
        end
        gate = 1'b1;
        wait_idle(12000);

        // Reset in the middle of a 100-byte frame, at its 30th written byte
        last_grant_t = -1000;
        add_ts(100);
        for (int n = 0; n < 400; n++) begin
            @(negedge i_clk);
            model_step();
            if (last_grant_t >= 0 && cyc == last_grant_t + 32) break;
        end
        check("rst_target_reached", cyc, last_grant_t + 32);
        #3;
        i_rst  = 1'b1;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        ts_q.delete();
        be_q.delete();
        sb.delete();
        for (int c = cyc; c < NC; c++) begin
            exp_ts_ack[c] = 1'b0; exp_be_ack[c] = 1'b0;
            exp_ts_rd[c]  = 1'b0; exp_be_rd[c]  = 1'b0;
            exp_drop[c]   = 1'b0;
        end
        exp_ts_cnt = '0; exp_be_cnt = '0; exp_drop_cnt = '0;
        act_valid = 1'b0; pop_ts_at = -1; pop_be_at = -1;
        i_ts_req = 1'b0; i_be_req = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst   = 1'b0;
        free_at = cyc;
        mon_en  = 1'b1;
        add_ts(100);
        wait_idle(2000);
        check("post_rst_ts_cnt", ov_ts_tx_cnt, 1);
        check("post_rst_drop_cnt", ov_drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
